// File: rtl/uart_types_pkg.sv
// uart_types_pkg: shared types and constants for the UART receive path.
//   rx_entry_t      - one received character plus its parity/framing/break
//                     status, at the default 8-bit character width.
//   RX_TO_TICKS_DEF - default character timeout in baud_pulse ticks
//                     (4 characters x 10 bits x 16 oversample).
//   entry_has_err() - true when any status bit of an entry is set.
package uart_types_pkg;

   localparam int RX_DATA_W_DEF   = 8;
   localparam int RX_TO_TICKS_DEF = 640;

   typedef struct packed {
      logic [RX_DATA_W_DEF-1:0] data;
      logic                     pe;
      logic                     fe;
      logic                     bi;
   } rx_entry_t;

   function automatic logic entry_has_err(input logic pe, input logic fe, input logic bi);
      return pe | fe | bi;
   endfunction

endpackage

// File: rtl/uart_rx_to_timer.sv
// uart_rx_to_timer: saturating character-timeout counter for the RX buffer.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   clr         - synchronous clear (flush or FIFO-mode change)
//   activity    - push or pop request this cycle; restarts the count
//   empty       - buffer holds no entries; holds the count at zero
//   baud_pulse  - oversample tick, counted while the buffer is non-empty
//   timeout     - high while the count sits at TO_TICKS
module uart_rx_to_timer #(
   parameter int TO_TICKS = 640
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic activity,
   input  logic empty,
   input  logic baud_pulse,
   output logic timeout
);

   localparam int CNT_W = $clog2(TO_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_TICKS);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr || activity || empty) begin
         cnt_d = '0;
      end else if (baud_pulse && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_rx_buf.sv
// uart_rx_buf: receive character buffer between uart_rx_top and regs_uart.
// Stores each character with its PE/FE/BI status, first-word-fall-through.
// With en=0 it behaves as a single holding register (new pushes overwrite).
// Optional feature macro: UART_RXBUF_TIMEOUT_EN enables the character timeout;
// when undefined, timeout is tied low and baud_pulse is unused.
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   en                  - FIFO enable; 0 = depth-1 holding-register mode
//   flush               - synchronous clear, wins over push/pop
//   baud_pulse          - oversample tick for the timeout counter
//   push, din, *_i      - write a character and its status
//   pop                 - advance past the head entry
//   threshold           - trigger level, 0 disables thre_trigger
//   dout, *_o           - head character/status, zero when empty
//   empty, full, level  - occupancy
//   thre_trigger        - level >= threshold (threshold != 0)
//   overrun, underrun   - sticky, cleared by ovr_clr
//   err_in_fifo         - some stored entry carries an error bit
//   timeout             - character timeout pending
//
// Handshake: push and pop are single-cycle requests with no back-pressure;
// a push that cannot be stored is dropped (or overwrites the holding entry
// when en=0) and flagged by overrun, a pop on an empty buffer is ignored and
// flagged by underrun.
module uart_rx_buf
   import uart_types_pkg::*;
#(
   parameter int DATA_W   = RX_DATA_W_DEF,
   parameter int DEPTH    = 16,
   parameter int TO_TICKS = RX_TO_TICKS_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       flush,
   input  logic                       baud_pulse,
   input  logic                       push,
   input  logic [DATA_W-1:0]          din,
   input  logic                       pe_i,
   input  logic                       fe_i,
   input  logic                       bi_i,
   input  logic                       pop,
   input  logic [$clog2(DEPTH+1)-1:0] threshold,
   output logic [DATA_W-1:0]          dout,
   output logic                       pe_o,
   output logic                       fe_o,
   output logic                       bi_o,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       thre_trigger,
   output logic                       overrun,
   output logic                       underrun,
   output logic                       err_in_fifo,
   output logic                       timeout,
   input  logic                       ovr_clr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              pe;
      logic              fe;
      logic              bi;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic             en_q;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d, err_cnt_q, err_cnt_d;
   logic             overrun_q, overrun_d, underrun_q, underrun_d;

   entry_t           head, wr_entry;
   logic [PTR_W-1:0] wr_idx;
   logic             soft_clr, empty_s, full_s, do_pop, grow, overwrite, we;
   logic             new_err, head_err;

   always_comb begin
      // Any change of FIFO mode restarts the buffer from a clean state.
      soft_clr  = flush | (en != en_q);
      empty_s   = (level_q == '0);
      full_s    = en ? (level_q == LVL_W'(DEPTH)) : (level_q == LVL_W'(1));
      head      = mem_q[rd_ptr_q];
      wr_entry  = '{data: din, pe: pe_i, fe: fe_i, bi: bi_i};
      new_err   = entry_has_err(pe_i, fe_i, bi_i);
      head_err  = entry_has_err(head.pe, head.fe, head.bi);
      do_pop    = pop & ~empty_s;
      // A push is stored as a new entry unless full; a same-cycle pop frees
      // the slot, so push+pop while full still stores.
      grow      = push & (~full_s | do_pop);
      // Holding-register mode replaces the single entry in place.
      overwrite = push & full_s & ~en & ~do_pop;
      we        = (grow | overwrite) & ~soft_clr;
      wr_idx    = overwrite ? rd_ptr_q : wr_ptr_q;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      err_cnt_d  = err_cnt_q;
      overrun_d  = overrun_q;
      underrun_d = underrun_q;

      if (soft_clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         err_cnt_d  = '0;
         overrun_d  = 1'b0;
         underrun_d = 1'b0;
      end else begin
         if (grow)   wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         level_d   = level_q + LVL_W'(grow) - LVL_W'(do_pop);
         err_cnt_d = err_cnt_q
                   + LVL_W'((grow | overwrite) & new_err)
                   - LVL_W'((do_pop | overwrite) & head_err);
         // Set events take precedence over the LSR-read clear.
         overrun_d  = (overrun_q & ~ovr_clr) | (push & full_s & ~do_pop);
         underrun_d = (underrun_q & ~ovr_clr) | (pop & empty_s);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q       <= en;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         err_cnt_q  <= '0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         en_q       <= en;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         err_cnt_q  <= err_cnt_d;
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
      end
   end

   // Storage needs no reset: level_q gates every visible read.
   always_ff @(posedge clk) begin
      if (we) mem_q[wr_idx] <= wr_entry;
   end

   assign dout         = empty_s ? '0 : head.data;
   assign pe_o         = ~empty_s & head.pe;
   assign fe_o         = ~empty_s & head.fe;
   assign bi_o         = ~empty_s & head.bi;
   assign empty        = empty_s;
   assign full         = full_s;
   assign level        = level_q;
   assign thre_trigger = (threshold != '0) && (level_q >= threshold);
   assign overrun      = overrun_q;
   assign underrun     = underrun_q;
   assign err_in_fifo  = (err_cnt_q != '0);

`ifdef UART_RXBUF_TIMEOUT_EN
   uart_rx_to_timer #(
      .TO_TICKS (TO_TICKS)
   ) u_to_timer (
      .clk        (clk),
      .rst        (rst),
      .clr        (soft_clr),
      .activity   (push | pop),
      .empty      (empty_s),
      .baud_pulse (baud_pulse),
      .timeout    (timeout)
   );
`else
   logic unused_baud_pulse;
   assign unused_baud_pulse = baud_pulse;
   assign timeout = 1'b0;
`endif

endmodule
